// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for the register file, write-back
// mux and registered ALU. It takes one command at a time over valid/ready,
// then drives the regfile addresses, ALU op, mux select and write enable.
// It pulses done (and err for illegal ops) when a command retires, and keeps
// a sticky overflow flag for ADD/SUB.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a command; cmd_ready high
// LDI    | load immediate: imm selected, write_enb high for one cycle
// READ   | operands addressed and held for ALU_LAT cycles
// WB     | ALU result written back; ADD/SUB overflow captured here
// ERR    | illegal op: no write, done+err follow
// DONE   | done pulse; back to IDLE
module alu_op_sequencer #(
   parameter int ALU_LAT = 2,
   parameter int OP_MAX  = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_kind_i,
   input  logic [3:0]  cmd_op_i,
   input  logic [4:0]  cmd_rs_i,
   input  logic [4:0]  cmd_rt_i,
   input  logic [4:0]  cmd_rd_i,
   input  logic [4:0]  cmd_shamt_i,
   input  logic [31:0] cmd_imm_i,
   output logic [4:0]  read_reg1_o,
   output logic [4:0]  read_reg2_o,
   output logic [4:0]  write_reg_o,
   output logic [31:0] imm_data_o,
   output logic        mux_sel_o,
   output logic        write_enb_o,
   output logic [3:0]  alu_op_o,
   output logic [4:0]  shift_amt_o,
   input  logic        alu_ovf_i,
   input  logic        ovf_clr_i,
   output logic        done_o,
   output logic        err_o,
   output logic        ovf_sticky_o
);

   localparam int              CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);
   localparam logic [3:0]      OP_LAST  = 4'(OP_MAX);
   localparam logic [3:0]      OP_ADD   = 4'd0;
   localparam logic [3:0]      OP_SUB   = 4'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LDI,
      S_READ,
      S_WB,
      S_ERR,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [4:0]       read_reg1_q;
   logic [4:0]       read_reg2_q;
   logic [4:0]       write_reg_q;
   logic [31:0]      imm_data_q;
   logic             mux_sel_q;
   logic             write_enb_q;
   logic [3:0]       alu_op_q;
   logic [4:0]       shift_amt_q;
   logic             done_q;
   logic             err_q;
   logic             ovf_sticky_q;

   // Operand hold counter advances by one each READ cycle.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   // Sequencer FSM with registered outputs; command fields latched on accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         read_reg1_q  <= '0;
         read_reg2_q  <= '0;
         write_reg_q  <= '0;
         imm_data_q   <= '0;
         mux_sel_q    <= 1'b0;
         write_enb_q  <= 1'b0;
         alu_op_q     <= '0;
         shift_amt_q  <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
      end else begin
         write_enb_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         // A same-cycle overflow set below overrides this clear.
         if (ovf_clr_i) begin
            ovf_sticky_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  read_reg1_q <= cmd_rs_i;
                  read_reg2_q <= cmd_rt_i;
                  write_reg_q <= cmd_rd_i;
                  imm_data_q  <= cmd_imm_i;
                  alu_op_q    <= cmd_op_i;
                  shift_amt_q <= cmd_shamt_i;
                  mux_sel_q   <= cmd_kind_i;
                  cnt_q       <= '0;
                  if (!cmd_kind_i) begin
                     state_q     <= S_LDI;
                     write_enb_q <= 1'b1;
                  end else if (cmd_op_i > OP_LAST) begin
                     state_q <= S_ERR;
                  end else begin
                     state_q <= S_READ;
                  end
               end
            end
            S_LDI: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_READ: begin
               if (cnt_q == CNT_LAST) begin
                  state_q     <= S_WB;
                  write_enb_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_WB: begin
               if (((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) && alu_ovf_i) begin
                  ovf_sticky_q <= 1'b1;
               end
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_ERR: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
               err_q   <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o  = (state_q == S_IDLE) && !rst_i;
   assign read_reg1_o  = read_reg1_q;
   assign read_reg2_o  = read_reg2_q;
   assign write_reg_o  = write_reg_q;
   assign imm_data_o   = imm_data_q;
   assign mux_sel_o    = mux_sel_q;
   assign write_enb_o  = write_enb_q;
   assign alu_op_o     = alu_op_q;
   assign shift_amt_o  = shift_amt_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign ovf_sticky_o = ovf_sticky_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives alu_op_sequencer against a behavioural
// register file and registered ALU, with a scoreboard of expected retirements.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_kind = 1'b0;
   logic [3:0]  cmd_op = '0;
   logic [4:0]  cmd_rs = '0;
   logic [4:0]  cmd_rt = '0;
   logic [4:0]  cmd_rd = '0;
   logic [4:0]  cmd_shamt = '0;
   logic [31:0] cmd_imm = '0;
   logic [4:0]  read_reg1, read_reg2, write_reg;
   logic [31:0] imm_data;
   logic        mux_sel, write_enb;
   logic [3:0]  alu_op;
   logic [4:0]  shift_amt;
   logic        alu_ovf;
   logic        ovf_clr = 1'b0;
   logic        done, err, ovf_sticky;

   alu_op_sequencer dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_kind_i   (cmd_kind),
      .cmd_op_i     (cmd_op),
      .cmd_rs_i     (cmd_rs),
      .cmd_rt_i     (cmd_rt),
      .cmd_rd_i     (cmd_rd),
      .cmd_shamt_i  (cmd_shamt),
      .cmd_imm_i    (cmd_imm),
      .read_reg1_o  (read_reg1),
      .read_reg2_o  (read_reg2),
      .write_reg_o  (write_reg),
      .imm_data_o   (imm_data),
      .mux_sel_o    (mux_sel),
      .write_enb_o  (write_enb),
      .alu_op_o     (alu_op),
      .shift_amt_o  (shift_amt),
      .alu_ovf_i    (alu_ovf),
      .ovf_clr_i    (ovf_clr),
      .done_o       (done),
      .err_o        (err),
      .ovf_sticky_o (ovf_sticky)
   );

   always #5 clk = ~clk;

   // ALU behaviour: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LESS.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return 32'($signed(a) >>> sh);
         4'd8:    return {31'd0, ($signed(a) < $signed(b))};
         default: return 32'd0;
      endcase
   endfunction

   // Environment: register file and registered ALU steered by the DUT outputs.
   logic [31:0] rf [32] = '{default: 32'd0};
   logic [31:0] a_r = '0, b_r = '0, res_r = '0;
   logic [3:0]  op_r = '0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      a_r   <= rf[read_reg1];
      b_r   <= rf[read_reg2];
      op_r  <= alu_op;
      res_r <= alu_fn(alu_op, rf[read_reg1], rf[read_reg2], shift_amt);
      if (write_enb) rf[write_reg] <= mux_sel ? res_r : imm_data;
   end

   // Overflow derived from the previously registered operands and result.
   assign alu_ovf = (op_r == 4'd0) ? ((a_r[31] == b_r[31]) && (res_r[31] != a_r[31])) :
                    (op_r == 4'd1) ? ((a_r[31] != b_r[31]) && (res_r[31] != a_r[31])) : 1'b0;

   // Monitor: records retirements and write-enable pulses.
   int   done_cnt = 0, done_cyc = 0, wen_total = 0, done_wen = 0, stray_err = 0;
   logic done_err = 1'b0, done_ovf = 1'b0;

   always @(negedge clk) begin
      if (write_enb) wen_total <= wen_total + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         done_err <= err;
         done_ovf <= ovf_sticky;
         done_wen <= wen_total + (write_enb ? 1 : 0);
      end
      if (err && !done) stray_err <= stray_err + 1;
   end

   // Scoreboard and reference model.
   typedef struct {
      int          lat;
      logic        err;
      int          wens;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        sticky;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] ref_rf [32] = '{default: 32'd0};
   logic        ref_sticky = 1'b0;
   int          n_chk = 0, n_pass = 0, n_issued = 0;
   int          acc_cyc = 0, wen_base = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Present a command and wait (bounded) for it to be accepted.
   task automatic drive_accept(input logic kind, input logic [3:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] sh, input logic [31:0] imm);
      @(negedge clk);
      cmd_kind = kind; cmd_op = op; cmd_rs = rs; cmd_rt = rt;
      cmd_rd = rd; cmd_shamt = sh; cmd_imm = imm; cmd_valid = 1'b1;
      #1;
      for (int i = 0; i < 50 && !cmd_ready; i++) begin
         @(negedge clk);
         #1;
      end
      chk("accept_ready", cmd_ready, 1'b1);
      acc_cyc  = cyc;
      wen_base = wen_total;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Push the expectation, drive the command, then pop and compare at done.
   task automatic issue(input logic kind, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [31:0] imm);
      exp_t    e;
      int      d0;
      longint  s;
      e.rd = rd;
      if (!kind) begin
         e.lat = 2; e.err = 1'b0; e.wens = 1; e.data = imm;
         ref_rf[rd] = imm;
      end else if (op > 4'd8) begin
         e.lat = 2; e.err = 1'b1; e.wens = 0; e.data = ref_rf[rd];
      end else begin
         e.lat = 4; e.err = 1'b0; e.wens = 1;
         e.data = alu_fn(op, ref_rf[rs], ref_rf[rt], sh);
         if (op == 4'd0) s = longint'($signed(ref_rf[rs])) + longint'($signed(ref_rf[rt]));
         else            s = longint'($signed(ref_rf[rs])) - longint'($signed(ref_rf[rt]));
         if (op <= 4'd1 && (s > 64'sd2147483647 || s < -64'sd2147483648)) ref_sticky = 1'b1;
         ref_rf[rd] = e.data;
      end
      e.sticky = ref_sticky;
      sb.push_back(e);
      n_issued++;
      d0 = done_cnt;
      drive_accept(kind, op, rs, rt, rd, sh, imm);
      for (int i = 0; i < 20 && done_cnt == d0; i++) begin
         @(negedge clk);
         #1;
      end
      chk("done_seen", done_cnt, d0 + 1);
      e = sb.pop_front();
      chk("latency", done_cyc - acc_cyc, e.lat);
      chk("err", done_err, e.err);
      chk("wen_pulses", done_wen - wen_base, e.wens);
      chk("rf_data", rf[e.rd], e.data);
      chk("ovf_sticky", done_ovf, e.sticky);
   endtask

   initial begin
      int d0;
      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_wen", write_enb, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_imm", imm_data, 32'd0);
      chk("rst_ovf", ovf_sticky, 1'b0);
      rst = 1'b0;
      #1;
      chk("ready_idle", cmd_ready, 1'b1);

      issue(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd1);          // LDI r0=1 (r0 writable)
      issue(1'b0, 4'd0, 5'd0, 5'd0, 5'd1, 5'd0, 32'd5);          // LDI r1=5
      issue(1'b0, 4'd0, 5'd0, 5'd0, 5'd2, 5'd0, 32'd8);          // LDI r2=8
      issue(1'b1, 4'd0, 5'd0, 5'd1, 5'd4, 5'd0, 32'd0);          // ADD r4=6
      issue(1'b1, 4'd1, 5'd1, 5'd2, 5'd5, 5'd0, 32'd0);          // SUB r5=-3
      issue(1'b1, 4'd8, 5'd5, 5'd0, 5'd10, 5'd0, 32'd0);         // LESS (highest legal op)
      issue(1'b1, 4'd9, 5'd0, 5'd1, 5'd4, 5'd0, 32'd0);          // first illegal op
      issue(1'b1, 4'hF, 5'd0, 5'd1, 5'd5, 5'd0, 32'd0);          // illegal op F
      issue(1'b0, 4'd0, 5'd0, 5'd0, 5'd6, 5'd0, 32'h7FFF_FFFF);  // LDI r6
      issue(1'b0, 4'd0, 5'd0, 5'd0, 5'd7, 5'd0, 32'd1);          // LDI r7
      issue(1'b1, 4'd0, 5'd6, 5'd7, 5'd8, 5'd0, 32'd0);          // ADD overflow

      @(negedge clk); ovf_clr = 1'b1;
      @(negedge clk); ovf_clr = 1'b0; ref_sticky = 1'b0;
      chk("ovf_clr", ovf_sticky, 1'b0);

      issue(1'b1, 4'd1, 5'd8, 5'd7, 5'd11, 5'd0, 32'd0);         // SUB overflow
      issue(1'b1, 4'd7, 5'd8, 5'd0, 5'd8, 5'd4, 32'd0);          // SRA with rd==rs
      @(negedge clk); ovf_clr = 1'b1;
      @(negedge clk); ref_sticky = 1'b0;
      chk("ovf_clr2", ovf_sticky, 1'b0);
      issue(1'b1, 4'd0, 5'd6, 5'd6, 5'd13, 5'd0, 32'd0);         // set beats held clear
      ovf_clr = 1'b0;
      @(negedge clk); ovf_clr = 1'b1;
      @(negedge clk); ovf_clr = 1'b0; ref_sticky = 1'b0;
      chk("ovf_clr3", ovf_sticky, 1'b0);

      // Reset while an ADD is in READ: the command is lost.
      d0 = done_cnt;
      drive_accept(1'b1, 4'd0, 5'd0, 5'd1, 5'd9, 5'd0, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", cmd_ready, 1'b1);
      repeat (6) @(negedge clk);
      #1;
      chk("rst_no_done", done_cnt, d0);
      chk("rst_no_wen", wen_total - wen_base, 0);
      chk("rst_no_write", rf[9], ref_rf[9]);
      issue(1'b0, 4'd0, 5'd0, 5'd0, 5'd9, 5'd0, 32'h0000_1234);  // LDI after reset

      chk("done_total", done_cnt, n_issued);
      chk("stray_err", stray_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
